des_round_decrypter: RTL and testbench

DES_ROUND_DECRYPTER -- requirements
Module: des_round_decrypter

---
 rtl/des_round_decrypter.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_des_round_decrypter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_decrypter.sv
// des_round_decrypter: iterative FIPS 46-3 DES decryption, one Feistel round
// per clock through a single shared fFunction instance. Bit [63] of every
// 64-bit bus is FIPS bit 1.
// Optional feature: define DES_DEC_CBC_MODE_EN to add CBC chaining
// (iv / iv_load ports); without it the block is plain ECB.

// DES round function: E expansion, subkey mix, S-boxes, P permutation.
module fFunction (
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] f_o
);
  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32, 1};

  localparam int P_T [32] = '{
    16, 7,20,21, 29,12,28,17,  1,15,23,26,  5,18,31,10,
     2, 8,24,14, 32,27, 3, 9, 19,13,30, 6, 22,11, 4,25};

  // Eight boxes of 4 rows x 16 columns, flattened box-major.
  localparam int SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  function automatic logic [47:0] expand(input logic [31:0] r);
    logic [47:0] e;
    for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_T[i])];
    return e;
  endfunction

  // Each 6-bit group: outer bits select the row, inner four the column.
  function automatic logic [31:0] subst(input logic [47:0] x);
    logic [31:0] s;
    logic [5:0]  c;
    for (int b = 0; b < 8; b++) begin
      c = x[6'(42 - 6 * b) +: 6];
      s[5'(28 - 4 * b) +: 4] = 4'(SBOX[{3'(b), c[5], c[0], c[4:1]}]);
    end
    return s;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] s);
    logic [31:0] p;
    for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_T[i])];
    return p;
  endfunction

  assign f_o = perm_p(subst(expand(r_i) ^ k_i));
endmodule

module des_round_decrypter #(
  parameter int KEY_PARITY_CHK = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] key,
`ifdef DES_DEC_CBC_MODE_EN
  input  logic [63:0] iv,
  input  logic        iv_load,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        key_err,
  output logic        busy
);
  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4,
    62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
    57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3,
    61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7};

  localparam int FP_T [64] = '{
    40, 8,48,16,56,24,64,32, 39, 7,47,15,55,23,63,31,
    38, 6,46,14,54,22,62,30, 37, 5,45,13,53,21,61,29,
    36, 4,44,12,52,20,60,28, 35, 3,43,11,51,19,59,27,
    34, 2,42,10,50,18,58,26, 33, 1,41, 9,49,17,57,25};

  localparam int PC1_T [56] = '{
    57,49,41,33,25,17, 9,  1,58,50,42,34,26,18, 10, 2,59,51,43,35,27,
    19,11, 3,60,52,44,36, 63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
    14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};

  localparam int PC2_T [48] = '{
    14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  // Round 16 wraps the 4-bit round counter back to zero.
  localparam logic [3:0] LAST_RND = 4'd0;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] k);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] cd);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return y;
  endfunction

  // True when any key byte has even parity (DES keys use odd parity).
  function automatic logic parity_bad(input logic [63:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) bad = bad | ~(^k[6'(8 * b) +: 8]);
    return bad;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] out_q, out_d;
  logic        ovld_q, ovld_d;
  logic        kerr_q, kerr_d;
`ifdef DES_DEC_CBC_MODE_EN
  logic [63:0] chain_q, chain_d;
  logic [63:0] ct_q, ct_d;
`endif

  logic [63:0] ip_in;
  logic [55:0] pc1_key;
  logic [27:0] c_rnd, d_rnd;
  logic [47:0] subkey;
  logic [31:0] f_out;
  logic [63:0] plain;

  assign ip_in   = perm_ip(in_data);
  assign pc1_key = perm_pc1(key);
  assign subkey  = perm_pc2({c_rnd, d_rnd});
  assign plain   = perm_fp({l_q ^ f_out, r_q});

  fFunction u_f (
    .r_i (r_q),
    .k_i (subkey),
    .f_o (f_out)
  );

  // Reverse key schedule: round 1 uses C0/D0 as-is, later rounds rotate right.
  always_comb begin
    c_rnd = c_q;
    d_rnd = d_q;
    if (rnd_q == 4'd2 || rnd_q == 4'd9 || rnd_q == LAST_RND) begin
      c_rnd = {c_q[0], c_q[27:1]};
      d_rnd = {d_q[0], d_q[27:1]};
    end else if (rnd_q != 4'd1) begin
      c_rnd = {c_q[1:0], c_q[27:2]};
      d_rnd = {d_q[1:0], d_q[27:2]};
    end
  end

  // Control FSM and next-state values for the round datapath.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    out_d   = out_q;
    ovld_d  = ovld_q;
    kerr_d  = kerr_q;
`ifdef DES_DEC_CBC_MODE_EN
    chain_d = chain_q;
    ct_d    = ct_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef DES_DEC_CBC_MODE_EN
        if (iv_load) chain_d = iv;
`endif
        if (in_valid) begin
          state_d = ROUND;
          {l_d, r_d} = ip_in;
          {c_d, d_d} = pc1_key;
          rnd_d   = 4'd1;
          kerr_d  = (KEY_PARITY_CHK != 0) ? parity_bad(key) : 1'b0;
`ifdef DES_DEC_CBC_MODE_EN
          ct_d    = in_data;
`endif
        end
      end
      ROUND: begin
        l_d   = r_q;
        r_d   = l_q ^ f_out;
        c_d   = c_rnd;
        d_d   = d_rnd;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) begin
          state_d = DONE;
          ovld_d  = 1'b1;
`ifdef DES_DEC_CBC_MODE_EN
          out_d   = plain ^ chain_q;
`else
          out_d   = plain;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          ovld_d  = 1'b0;
`ifdef DES_DEC_CBC_MODE_EN
          chain_d = ct_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      out_q   <= '0;
      ovld_q  <= 1'b0;
      kerr_q  <= 1'b0;
`ifdef DES_DEC_CBC_MODE_EN
      chain_q <= '0;
      ct_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      out_q   <= out_d;
      ovld_q  <= ovld_d;
      kerr_q  <= kerr_d;
`ifdef DES_DEC_CBC_MODE_EN
      chain_q <= chain_d;
      ct_q    <= ct_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ovld_q;
  assign out_data  = out_q;
  assign key_err   = kerr_q;
endmodule

// File: tb/tb_des_round_decrypter.sv
// Scoreboard bench for des_round_decrypter: the driver pushes each expected
// plaintext when it issues a block, and a monitor pops and compares on every
// out_valid/out_ready handshake.
module tb_des_round_decrypter;
  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] K1_BAD = 64'h133457799BBCDFF0;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2 = 64'h0000000000000000;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] K3 = 64'h0101010101010101;
  localparam logic [63:0] C3 = 64'h95F8A5E5DD31D900;
  localparam logic [63:0] P3 = 64'h8000000000000000;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic in_ready, out_valid, key_err, busy;
  logic [63:0] in_data, key, out_data;
`ifdef DES_DEC_CBC_MODE_EN
  logic [63:0] iv;
  logic        iv_load;
  logic [63:0] cbc_iv = 64'h0;
  bit          cbc_keep = 1'b0;
`endif

  typedef struct packed { logic [63:0] data; logic kerr; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  time  t_last, t_first;
  bit   seen;

  always #5 clk = ~clk;

  des_round_decrypter #(.KEY_PARITY_CHK(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key       (key),
`ifdef DES_DEC_CBC_MODE_EN
    .iv        (iv),
    .iv_load   (iv_load),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .key_err   (key_err),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every accepted plaintext is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %h, required no output", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("plaintext", out_data, mon_e.data);
        check("key_err_at_output", 64'(key_err), 64'(mon_e.kerr));
      end
    end
  end

  // Issue one block and walk it through to the output handshake.
  // Starts and ends at a falling edge.
  task automatic send(input logic [63:0] ct, input logic [63:0] k, input logic [63:0] pt,
                      input logic ke, input int hold, input bit early);
    int   cnt;
    exp_t e;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_wait: got %b, required 1", in_ready);
      return;
    end
    if (early) out_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = ct;
    key      = k;
`ifdef DES_DEC_CBC_MODE_EN
    iv       = cbc_iv;
    iv_load  = !cbc_keep;
`endif
    e.data = pt;
    e.kerr = ke;
    exp_q.push_back(e);
    @(posedge clk);
    t_last = $time;
    #1;
    in_valid = 1'b0;
    in_data  = ~ct;
    key      = ~k;
`ifdef DES_DEC_CBC_MODE_EN
    iv_load  = 1'b0;
    iv       = ~cbc_iv;
`endif
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      if (cnt == 0) begin
        check("busy_in_round", 64'(busy), 64'd1);
        check("in_ready_in_round", 64'(in_ready), 64'd0);
        check("key_err_registered", 64'(key_err), 64'(ke));
      end
      if (out_valid === 1'b1) break;
      @(posedge clk);
      cnt++;
    end
    if (out_valid !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_valid_wait: got %b, required 1", out_valid);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b0;
      exp_q.delete();
      @(negedge clk);
      return;
    end
    // Edges from acceptance to the first edge that samples out_valid high.
    check("out_valid_latency", 64'(cnt + 1), 64'd17);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_out_data", out_data, pt);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    if (!early) begin
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_out_data_held", out_data, pt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit, required $finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; key = '0;
`ifdef DES_DEC_CBC_MODE_EN
    iv = '0; iv_load = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_key_err", 64'(key_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Known-answer vectors, parity error and output stall.
    send(C1, K1, P1, 1'b0, 0, 1'b0);
    send(C2, K2, P2, 1'b0, 0, 1'b0);
    send(C3, K3, P3, 1'b0, 0, 1'b0);
    send(C1, K1, P1, 1'b0, 5, 1'b0);
    send(C1, K1_BAD, P1, 1'b1, 0, 1'b0);

    // Abort a block with rst at round 8; no output may appear.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = C2;
    key       = K2;
`ifdef DES_DEC_CBC_MODE_EN
    iv = '0; iv_load = 1'b1;
`endif
    @(posedge clk);
    #1 in_valid = 1'b0;
`ifdef DES_DEC_CBC_MODE_EN
    iv_load = 1'b0;
`endif
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_data", out_data, 64'd0);
    check("abort_key_err", 64'(key_err), 64'd0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("abort_no_out_valid", 64'(seen), 64'd0);
    out_ready = 1'b0;
    send(C1, K1, P1, 1'b0, 0, 1'b0);

    // Back-to-back blocks with out_ready held high: minimum turnaround.
    send(C1, K1, P1, 1'b0, 0, 1'b1);
    t_first = t_last;
    send(C2, K2, P2, 1'b0, 0, 1'b1);
    check("turnaround_cycles", 64'((t_last - t_first) / 10), 64'd18);

`ifdef DES_DEC_CBC_MODE_EN
    // Two chained blocks under one IV loaded alongside the first block.
    cbc_iv   = 64'h0123456789ABCDEF;
    cbc_keep = 1'b0;
    send(C1, K1, 64'h0000000000000000, 1'b0, 0, 1'b0);
    cbc_keep = 1'b1;
    send(C1, K1, 64'h84CB563386A179EA, 1'b0, 0, 1'b0);
    cbc_keep = 1'b0;
    cbc_iv   = 64'h0;
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
